gabor_window_5x5: RTL and testbench

Streaming 5x5 window generator directly upstream of the grouped-coefficient Gabor convolution blocks. Accepts one signed pixel per cycle in raster order over a padded frame and buffers the four previous rows. When a full kernel footprint is available, it presents all 25 window pixels in parallel as `pixel1`..`pixel25`, ready for the convolution stage. A valid/ready handshake on both sides lets the downstream stage stall the stream.

---
 rtl/gabor_window_5x5_if.sv | 43 ++++
 rtl/gabor_window_5x5.sv | 147 ++++++++++++++
 tb/tb_gabor_window_5x5.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gabor_window_5x5_if.sv
// gabor_window_5x5_if
// Stream and window bus for the 5x5 Gabor window generator.
//   in_valid / in_sof / in_pixel / in_ready : raster-order pixel input stream
//   out_valid / out_ready                   : window handshake toward the convolution stage
//   pixel1..pixel25                         : window pixels, row-major, pixel1 = oldest/leftmost
//   frame_done                              : one-cycle pulse after the last pixel of a frame
// Modports: master = pixel source / window sink, slave = window generator.
interface gabor_window_5x5_if #(
    parameter int unsigned PW = 9
) ();
    logic                 in_valid;
    logic                 in_sof;
    logic signed [PW-1:0] in_pixel;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 frame_done;
    logic signed [PW-1:0] pixel1,  pixel2,  pixel3,  pixel4,  pixel5;
    logic signed [PW-1:0] pixel6,  pixel7,  pixel8,  pixel9,  pixel10;
    logic signed [PW-1:0] pixel11, pixel12, pixel13, pixel14, pixel15;
    logic signed [PW-1:0] pixel16, pixel17, pixel18, pixel19, pixel20;
    logic signed [PW-1:0] pixel21, pixel22, pixel23, pixel24, pixel25;

    modport master (
        output in_valid, in_sof, in_pixel, out_ready,
        input  in_ready, out_valid, frame_done,
        input  pixel1,  pixel2,  pixel3,  pixel4,  pixel5,
        input  pixel6,  pixel7,  pixel8,  pixel9,  pixel10,
        input  pixel11, pixel12, pixel13, pixel14, pixel15,
        input  pixel16, pixel17, pixel18, pixel19, pixel20,
        input  pixel21, pixel22, pixel23, pixel24, pixel25
    );

    modport slave (
        input  in_valid, in_sof, in_pixel, out_ready,
        output in_ready, out_valid, frame_done,
        output pixel1,  pixel2,  pixel3,  pixel4,  pixel5,
        output pixel6,  pixel7,  pixel8,  pixel9,  pixel10,
        output pixel11, pixel12, pixel13, pixel14, pixel15,
        output pixel16, pixel17, pixel18, pixel19, pixel20,
        output pixel21, pixel22, pixel23, pixel24, pixel25
    );
endinterface

// File: rtl/gabor_window_5x5.sv
// gabor_window_5x5
// Streaming 5x5 window generator. Buffers the four previous rows of a padded frame in
// line-buffer RAMs and presents a full 5x5 window once the kernel footprint is complete.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : gabor_window_5x5_if.slave (pixel input stream, window output, frame_done)
module gabor_window_5x5 #(
    parameter int unsigned pixel_int_width = 9,
    parameter int unsigned pixel_dec_width = 0,
    parameter int unsigned image_width     = 516,
    parameter int unsigned image_height    = 516,
    parameter int unsigned kernel_size     = 5
) (
    input logic           clk,
    input logic           rst,
    gabor_window_5x5_if.slave bus
);
    localparam int unsigned PW = pixel_int_width + pixel_dec_width;
    localparam int unsigned CW = $clog2(image_width);
    localparam int unsigned RW = $clog2(image_height);
    localparam logic [CW-1:0] ColLast = CW'(image_width - 1);
    localparam logic [RW-1:0] RowLast = RW'(image_height - 1);

    if (kernel_size != 5) begin : g_bad_kernel
        $error("gabor_window_5x5: kernel_size must be 5");
    end
    if (image_width < 5 || image_height < 5) begin : g_bad_frame
        $error("gabor_window_5x5: image_width and image_height must be at least 5");
    end

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          acc;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;

    logic signed [PW-1:0] lb_mem  [4][image_width];
    logic signed [PW-1:0] lb_rd_q [4];
    logic signed [PW-1:0] win_q   [5][5];

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign acc          = bus.in_valid && bus.in_ready;

    // A start-of-frame pixel is taken as (0,0) regardless of the running position.
    assign col_cur = bus.in_sof ? '0 : col_q;
    assign row_cur = bus.in_sof ? '0 : row_q;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        if (acc) begin
            if (col_cur == ColLast) begin
                col_d = '0;
                row_d = (row_cur == RowLast) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
            // Columns below 4 never complete a window, so windows never span a row wrap.
            out_valid_d  = (row_cur >= RW'(4)) && (col_cur >= CW'(4));
            frame_done_d = (row_cur == RowLast) && (col_cur == ColLast);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Line buffers: synchronous-read RAMs. The read port prefetches the entry for the
    // position of the next pixel (col_d), so the data is registered and ready when that
    // pixel is accepted. The write on acc targets col_cur, which differs from col_d, so the
    // prefetched word is always the pre-write contents. After reset or a resync the first
    // prefetch may be stale; that only pollutes rows -1..-3, which shift out before row 4.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_mem[0][col_cur] <= bus.in_pixel;
            for (int k = 1; k < 4; k++) begin
                lb_mem[k][col_cur] <= lb_rd_q[k-1];
            end
        end
        for (int k = 0; k < 4; k++) begin
            lb_rd_q[k] <= lb_mem[k][col_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            if (acc) begin
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        win_q[i][j] <= win_q[i][j+1];
                    end
                end
                // Buffer k holds row (row-1-k), so buffer3 feeds the top window row.
                win_q[0][4] <= lb_rd_q[3];
                win_q[1][4] <= lb_rd_q[2];
                win_q[2][4] <= lb_rd_q[1];
                win_q[3][4] <= lb_rd_q[0];
                win_q[4][4] <= bus.in_pixel;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;

    assign bus.pixel1  = win_q[0][0];
    assign bus.pixel2  = win_q[0][1];
    assign bus.pixel3  = win_q[0][2];
    assign bus.pixel4  = win_q[0][3];
    assign bus.pixel5  = win_q[0][4];
    assign bus.pixel6  = win_q[1][0];
    assign bus.pixel7  = win_q[1][1];
    assign bus.pixel8  = win_q[1][2];
    assign bus.pixel9  = win_q[1][3];
    assign bus.pixel10 = win_q[1][4];
    assign bus.pixel11 = win_q[2][0];
    assign bus.pixel12 = win_q[2][1];
    assign bus.pixel13 = win_q[2][2];
    assign bus.pixel14 = win_q[2][3];
    assign bus.pixel15 = win_q[2][4];
    assign bus.pixel16 = win_q[3][0];
    assign bus.pixel17 = win_q[3][1];
    assign bus.pixel18 = win_q[3][2];
    assign bus.pixel19 = win_q[3][3];
    assign bus.pixel20 = win_q[3][4];
    assign bus.pixel21 = win_q[4][0];
    assign bus.pixel22 = win_q[4][1];
    assign bus.pixel23 = win_q[4][2];
    assign bus.pixel24 = win_q[4][3];
    assign bus.pixel25 = win_q[4][4];
endmodule

// File: tb/tb_gabor_window_5x5.sv
// tb_gabor_window_5x5
// Directed bench for gabor_window_5x5 on an 8x7 frame with pixel value row*16+col.
// Windows are captured when consumed (out_valid && out_ready before an edge) and compared
// against hand-picked constants and a position-based window model.
module tb_gabor_window_5x5;
    localparam int W = 8;
    localparam int H = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gabor_window_5x5_if #(.PW(9)) bus ();

    gabor_window_5x5 #(
        .pixel_int_width(9),
        .pixel_dec_width(0),
        .image_width    (W),
        .image_height   (H),
        .kernel_size    (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           fd_cnt   = 0;
    logic [8:0]   last_acc = '0;
    logic [8:0]   fd_last  = '0;
    logic [224:0] win_q[$];
    logic [224:0] ref_q[$];

    function automatic logic [8:0] pix_val(int idx);
        return 9'((idx / W) * 16 + (idx % W));
    endfunction

    // Window whose newest pixel sits at (r,c).
    function automatic logic [224:0] model_win(int r, int c);
        logic [224:0] m = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                m[(5 * i + j) * 9 +: 9] = 9'((r - 4 + i) * 16 + (c - 4 + j));
            end
        end
        return m;
    endfunction

    function automatic logic [8:0] wpix(logic [224:0] w, int n);
        return w[(n - 1) * 9 +: 9];
    endfunction

    task automatic cycle(input logic v, input logic sof, input logic [8:0] pix,
                         input logic ordy, output logic acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sof    = sof;
        bus.in_pixel  = pix;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        if (bus.out_valid && ordy) begin
            win_q.push_back({bus.pixel25, bus.pixel24, bus.pixel23, bus.pixel22, bus.pixel21,
                             bus.pixel20, bus.pixel19, bus.pixel18, bus.pixel17, bus.pixel16,
                             bus.pixel15, bus.pixel14, bus.pixel13, bus.pixel12, bus.pixel11,
                             bus.pixel10, bus.pixel9,  bus.pixel8,  bus.pixel7,  bus.pixel6,
                             bus.pixel5,  bus.pixel4,  bus.pixel3,  bus.pixel2,  bus.pixel1});
        end
        if (acc) last_acc = pix;
        @(posedge clk);
        #1;
        if (bus.frame_done) begin
            fd_cnt++;
            fd_last = last_acc;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'($urandom), 1'b1, acc);
    endtask

    // Sends pixels start..start+n-1 of the raster, holding each until accepted.
    task automatic stream(input bit sof_first, input bit bubbles, input int start, input int n);
        logic acc;
        int   tries;
        for (int i = 0; i < n; i++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 50) begin
                if (bubbles && $urandom_range(0, 1) == 1) begin
                    cycle(1'b0, 1'b0, 9'($urandom), 1'b1, acc);
                    acc = 1'b0;
                end else begin
                    cycle(1'b1, sof_first && (i == 0), pix_val(start + i), 1'b1, acc);
                end
                tries++;
            end
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_timeout: pixel %0d not accepted, required acceptance",
                         start + i);
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_pixel  = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
        end
        n_checks++;
        if (bus.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_done: got %b, required 0", bus.frame_done);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        n_checks++;
        if (bus.pixel1 !== 9'd0) begin
            n_fail++; $display("FAIL reset_pixel1: got %0d, required 0", bus.pixel1);
        end
        n_checks++;
        if (bus.pixel13 !== 9'd0) begin
            n_fail++; $display("FAIL reset_pixel13: got %0d, required 0", bus.pixel13);
        end
        n_checks++;
        if (bus.pixel25 !== 9'd0) begin
            n_fail++; $display("FAIL reset_pixel25: got %0d, required 0", bus.pixel25);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        win_q.delete();
        fd_cnt = 0;
        stream(1'b1, 1'b0, 0, W * H);
        idle(3);
        n_checks++;
        if (win_q.size() != 12) begin
            n_fail++; $display("FAIL full_count: got %0d windows, required 12", win_q.size());
        end else begin
            n_checks++;
            if (wpix(win_q[0], 1) !== 9'd0) begin
                n_fail++; $display("FAIL full_first_p1: got %0d, required 0", wpix(win_q[0], 1));
            end
            n_checks++;
            if (wpix(win_q[0], 5) !== 9'd4) begin
                n_fail++; $display("FAIL full_first_p5: got %0d, required 4", wpix(win_q[0], 5));
            end
            n_checks++;
            if (wpix(win_q[0], 13) !== 9'd34) begin
                n_fail++;
                $display("FAIL full_first_p13: got %0d, required 34", wpix(win_q[0], 13));
            end
            n_checks++;
            if (wpix(win_q[0], 21) !== 9'd64) begin
                n_fail++;
                $display("FAIL full_first_p21: got %0d, required 64", wpix(win_q[0], 21));
            end
            n_checks++;
            if (wpix(win_q[0], 25) !== 9'd68) begin
                n_fail++;
                $display("FAIL full_first_p25: got %0d, required 68", wpix(win_q[0], 25));
            end
            n_checks++;
            if (wpix(win_q[11], 25) !== 9'd103) begin
                n_fail++;
                $display("FAIL full_last_p25: got %0d, required 103", wpix(win_q[11], 25));
            end
            n_checks++;
            if (wpix(win_q[11], 1) !== 9'd35) begin
                n_fail++;
                $display("FAIL full_last_p1: got %0d, required 35", wpix(win_q[11], 1));
            end
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (win_q[k] !== model_win(4 + k / 4, 4 + k % 4)) begin
                    n_fail++;
                    $display("FAIL full_window_%0d: got %h, required %h", k, win_q[k],
                             model_win(4 + k / 4, 4 + k % 4));
                end
            end
        end
        n_checks++;
        if (fd_cnt != 1) begin
            n_fail++; $display("FAIL full_frame_done_count: got %0d, required 1", fd_cnt);
        end
        n_checks++;
        if (fd_last !== 9'd103) begin
            n_fail++; $display("FAIL full_frame_done_pixel: got %0d, required 103", fd_last);
        end
        ref_q = win_q;
    endtask

    task automatic test_backpressure();
        logic acc;
        win_q.delete();
        stream(1'b1, 1'b0, 0, 37);
        for (int s = 0; s < 3; s++) begin
            cycle(1'b1, 1'b0, pix_val(37), 1'b0, acc);
            n_checks++;
            if (acc !== 1'b0) begin
                n_fail++; $display("FAIL stall_in_ready_%0d: got %b, required 0", s, acc);
            end
            n_checks++;
            if (bus.pixel25 !== 9'd68 || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got pixel25=%0d valid=%b, required 68 valid=1",
                         s, bus.pixel25, bus.out_valid);
            end
        end
        stream(1'b0, 1'b0, 37, W * H - 37);
        idle(3);
        n_checks++;
        if (win_q.size() != 12) begin
            n_fail++; $display("FAIL stall_count: got %0d windows, required 12", win_q.size());
        end else begin
            n_checks++;
            if (wpix(win_q[1], 25) !== 9'd69) begin
                n_fail++;
                $display("FAIL stall_resume: got %0d, required 69", wpix(win_q[1], 25));
            end
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (win_q[k] !== ref_q[k]) begin
                    n_fail++;
                    $display("FAIL stall_window_%0d: got %h, required %h", k, win_q[k], ref_q[k]);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        win_q.delete();
        stream(1'b1, 1'b1, 0, W * H);
        idle(3);
        n_checks++;
        if (win_q.size() != 12) begin
            n_fail++; $display("FAIL bubble_count: got %0d windows, required 12", win_q.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (win_q[k] !== ref_q[k]) begin
                    n_fail++;
                    $display("FAIL bubble_window_%0d: got %h, required %h", k, win_q[k], ref_q[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        win_q.delete();
        fd_cnt = 0;
        stream(1'b1, 1'b0, 0, W * H);
        stream(1'b1, 1'b0, 0, 4 * W);
        n_checks++;
        if (win_q.size() != 12) begin
            n_fail++;
            $display("FAIL b2b_first_rows: got %0d windows, required 12", win_q.size());
        end
        stream(1'b0, 1'b0, 4 * W, W * H - 4 * W);
        idle(3);
        n_checks++;
        if (win_q.size() != 24) begin
            n_fail++; $display("FAIL b2b_count: got %0d windows, required 24", win_q.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (win_q[12 + k] !== ref_q[k]) begin
                    n_fail++;
                    $display("FAIL b2b_window_%0d: got %h, required %h", k, win_q[12 + k],
                             ref_q[k]);
                end
            end
        end
        n_checks++;
        if (fd_cnt != 2) begin
            n_fail++; $display("FAIL b2b_frame_done_count: got %0d, required 2", fd_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        stream(1'b1, 1'b0, 0, 5 * W + 3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.pixel25 !== 9'd0 || bus.pixel1 !== 9'd0) begin
            n_fail++;
            $display("FAIL midrst_pixels: got p1=%0d p25=%0d, required 0 0",
                     bus.pixel1, bus.pixel25);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flags: got valid=%b done=%b, required 0 0",
                     bus.out_valid, bus.frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        win_q.delete();
        stream(1'b0, 1'b0, 0, W * H);
        idle(3);
        n_checks++;
        if (win_q.size() != 12) begin
            n_fail++; $display("FAIL midrst_count: got %0d windows, required 12", win_q.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (win_q[k] !== ref_q[k]) begin
                    n_fail++;
                    $display("FAIL midrst_window_%0d: got %h, required %h", k, win_q[k],
                             ref_q[k]);
                end
            end
        end
    endtask

    task automatic test_mid_sof();
        win_q.delete();
        stream(1'b1, 1'b0, 0, 3 * W + 6);
        stream(1'b1, 1'b0, 0, 4 * W + 4);
        n_checks++;
        if (win_q.size() != 0) begin
            n_fail++;
            $display("FAIL midsof_early: got %0d windows before (4,4), required 0", win_q.size());
        end
        stream(1'b0, 1'b0, 4 * W + 4, W * H - 4 * W - 4);
        idle(3);
        n_checks++;
        if (win_q.size() != 12) begin
            n_fail++; $display("FAIL midsof_count: got %0d windows, required 12", win_q.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (win_q[k] !== ref_q[k]) begin
                    n_fail++;
                    $display("FAIL midsof_window_%0d: got %h, required %h", k, win_q[k],
                             ref_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_reset_mid_frame();
        test_mid_sof();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
